// File: rtl/debounce_pkg.sv
// debounce_pkg: shared channel state encoding and default timing constants
package debounce_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} ch_state_t;
  localparam int TICK_DIV_DEF = 3125000;
  localparam int STABLE_TICKS_DEF = 4;
endpackage

// File: rtl/debounce_scheduler_tick_gen.sv
// tick_gen: free-running sample tick, one clk wide every TICK_DIV enabled cycles
module tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam logic [25:0] LAST = 26'(TICK_DIV - 1);
  logic [25:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (enable) cnt <= cnt == LAST ? '0 : cnt + 26'd1;
  assign tick = enable && cnt == LAST;
endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: per-channel button debouncer sampled on a shared tick
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            tick_out
);
  localparam logic [2:0] ST = 3'(STABLE_TICKS);
  logic [N_CH-1:0] s1, sync, lvl_n, prs_n, rel_n;
  logic tick;
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, sync} <= '0;
    else {s1, sync} <= {btn_in, s1};
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .tick(tick)
  );
  assign tick_out = tick;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t st, st_n;
    logic [2:0] cnt, cnt_n;
    logic on, on_n;
    always_comb begin
      st_n = st;
      cnt_n = cnt;
      if (tick)
        case (st)
          IDLE:
            if (sync[i]) begin
              st_n = ST == 3'd1 ? HELD : PRESS_CHK;
              cnt_n = ST == 3'd1 ? 3'd0 : 3'd1;
            end
          PRESS_CHK:
            if (!sync[i]) begin
              st_n = IDLE;
              cnt_n = 3'd0;
            end else begin
              st_n = cnt + 3'd1 == ST ? HELD : PRESS_CHK;
              cnt_n = cnt + 3'd1 == ST ? 3'd0 : cnt + 3'd1;
            end
          HELD:
            if (!sync[i]) begin
              st_n = ST == 3'd1 ? IDLE : REL_CHK;
              cnt_n = ST == 3'd1 ? 3'd0 : 3'd1;
            end
          default:
            if (sync[i]) begin
              st_n = HELD;
              cnt_n = 3'd0;
            end else begin
              st_n = cnt + 3'd1 == ST ? IDLE : REL_CHK;
              cnt_n = cnt + 3'd1 == ST ? 3'd0 : cnt + 3'd1;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st <= IDLE;
        cnt <= 3'd0;
      end else begin
        st <= st_n;
        cnt <= cnt_n;
      end
    assign on = st == HELD || st == REL_CHK;
    assign on_n = st_n == HELD || st_n == REL_CHK;
    assign lvl_n[i] = on_n;
    assign prs_n[i] = !on && st_n == HELD;
    assign rel_n[i] = on && st_n == IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) {btn_level, btn_press, btn_release} <= '0;
    else {btn_level, btn_press, btn_release} <= {lvl_n, prs_n, rel_n};
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: scoreboarded check of debounce_scheduler against a run-length model
module tb_debounce_scheduler;
  localparam int N = 4, TD = 4, ST = 3;
  logic clk = 0, reset = 1, enable = 0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic tick_out;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  debounce_scheduler #(.N_CH(N), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .tick_out(tick_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: each channel tracks its accepted level and how many ticks in a row disagreed
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_prs = '0, m_rel = '0;
  int m_cnt = 0;
  int m_run[N] = '{default: 0};
  logic m_t;
  logic [12:0] sb[$];
  logic [12:0] e;

  always @(posedge clk) begin
    if (reset) begin
      {m_s1, m_s2, m_lvl, m_prs, m_rel} = '0;
      m_cnt = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      m_t = enable && m_cnt == TD - 1;
      m_prs = '0;
      m_rel = '0;
      if (m_t)
        for (int i = 0; i < N; i++)
          if (m_s2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == ST) begin
              m_lvl[i] = m_s2[i];
              m_prs[i] = m_s2[i];
              m_rel[i] = !m_s2[i];
              m_run[i] = 0;
            end
          end else m_run[i] = 0;
      if (enable) m_cnt = m_cnt == TD - 1 ? 0 : m_cnt + 1;
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
    sb.push_back({m_lvl, m_prs, m_rel, m_cnt == TD - 1});
  end

  always @(negedge clk)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (reset) e = '0;
      check("level", btn_level, e[12:9]);
      check("press", btn_press, e[8:5]);
      check("release", btn_release, e[4:1]);
      check("tick", tick_out, e[0] & enable);
    end

  task automatic set_btn(input logic [N-1:0] v);
    @(posedge clk);
    #2 btn_in = v;
  endtask

  task automatic wait_out(input string tag, input int sel, input logic [N-1:0] val,
                          input int limit, output int ticks);
    bit hit = 0;
    ticks = 0;
    for (int k = 0; k < limit && !hit; k++) begin
      @(negedge clk);
      if (tick_out) ticks++;
      hit = (sel == 0 ? btn_press : btn_release) == val;
    end
    check({tag, "_seen"}, 32'(hit), 1);
  endtask

  initial begin
    int tk, cnt, bad;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    enable = 1;
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      cnt += int'(tick_out);
    end
    check("tick_count", cnt, 4);

    set_btn(4'b0001);
    wait_out("press0", 0, 4'b0001, 40, tk);
    check("level0", btn_level[0], 1);

    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2 if (k % 3 == 0) btn_in[1] = ~btn_in[1];
      @(negedge clk);
      cnt += int'(btn_press[1]);
    end
    check("bounce_press1", cnt, 0);
    set_btn(4'b0011);
    wait_out("press1", 0, 4'b0010, 40, tk);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(btn_press[1]);
    end
    check("press1_once", cnt, 0);

    set_btn(4'b0000);
    wait_out("rel01", 1, 4'b0011, 40, tk);
    set_btn(4'b1001);
    wait_out("press03", 0, 4'b1001, 40, tk);
    set_btn(4'b0000);
    wait_out("rel03", 1, 4'b1001, 40, tk);

    set_btn(4'b0100);
    repeat (2) @(posedge clk);
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 2; k++) begin
      @(negedge clk);
      cnt += int'(tick_out);
    end
    check("pchk_ticks", cnt, 2);
    @(posedge clk);
    #2 reset = 1;
    @(negedge clk);
    check("rst_outputs", {btn_level, btn_press, btn_release, tick_out}, 0);
    repeat (2) @(posedge clk);
    #2 reset = 0;
    wait_out("press2_after_rst", 0, 4'b0100, 40, tk);
    check("press2_ticks", tk, 3);
    set_btn(4'b0000);
    wait_out("rel2", 1, 4'b0100, 40, tk);

    set_btn(4'b0001);
    wait_out("press0b", 0, 4'b0001, 40, tk);
    set_btn(4'b0000);
    repeat (2) @(posedge clk);
    cnt = 0;
    for (int k = 0; k < 10 && cnt < 1; k++) begin
      @(negedge clk);
      cnt += int'(tick_out);
    end
    check("relchk_tick", cnt, 1);
    @(posedge clk);
    #2 enable = 0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      bad += int'(tick_out || |btn_press || |btn_release || !btn_level[0]);
    end
    check("frozen", bad, 0);
    @(posedge clk);
    #2 enable = 1;
    wait_out("rel0_resume", 1, 4'b0001, 40, tk);
    check("resume_ticks", tk, 2);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
